// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous RAM controller.
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam int   RD_LAT_MAX = 4;

endpackage

// File: rtl/ram_sync_ctrl_if.sv
// Request/response bus between the load/store unit (master) and the RAM controller (slave).
interface ram_sync_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  import ram_pkg::*;

  logic                  Enable;
  logic                  RW;
  logic [ADDR_W-1:0]     Address;
  logic [DATA_W-1:0]     In;
  logic [DATA_W/8-1:0]   ByteEn;
  logic                  Ready;
  logic [DATA_W-1:0]     Out;
  logic                  OutValid;
  logic                  Err;

  modport master (
    output Enable, RW, Address, In, ByteEn,
    input  Ready, Out, OutValid, Err
  );

  modport slave (
    input  Enable, RW, Address, In, ByteEn,
    output Ready, Out, OutValid, Err
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-response delay line: RD_LAT stages of {valid, err, data}; data only advances with valid,
// so the last stage holds the most recent response while idle.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic              err_o,
  output logic [DATA_W-1:0] dat_o
);
  localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    err_q;
  logic [DATA_W-1:0] dat_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= '0;
      for (int s = 0; s < LAT; s++) dat_q[s] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      err_q[0] <= vld_i && err_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign err_o = err_q[LAT-1];
  assign dat_o = dat_q[LAT-1];
endmodule

// File: rtl/ram_sync_ctrl.sv
// Single-port synchronous RAM with byte-enable writes, pipelined reads and range checking.
// RAM_INIT_EN: when defined, a zeroing sweep over all words runs after every reset.
module ram_sync_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  ram_sync_ctrl_if.slave bus
);
  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic              accept, rd_acc, wr_acc, in_range;
  logic              init_done, clr_en;
  logic [IDX_W-1:0]  idx, clr_idx;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] rd_dat;
  logic              pipe_vld, pipe_err;
  logic [DATA_W-1:0] pipe_dat;

`ifdef RAM_INIT_EN
  localparam int             CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_en) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter parks at DEPTH once every word is cleared; that cycle hands over to RUN.
  assign clr_en    = (state_q == ST_INIT) && (cnt_q != CNT_LAST);
  assign clr_idx   = cnt_q[IDX_W-1:0];
  assign init_done = (cnt_q == CNT_LAST);
`else
  assign clr_en    = 1'b0;
  assign clr_idx   = '0;
  assign init_done = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.Ready = (state_q == ST_RUN);

  assign accept   = bus.Enable && bus.Ready;
  assign in_range = {1'b0, bus.Address} < DEPTH_W;
  assign idx      = bus.Address[IDX_W-1:0];
  assign rd_acc   = accept && (bus.RW == RW_READ);
  assign wr_acc   = accept && (bus.RW == RW_WRITE);

  // Clear sweep and requests are mutually exclusive because Ready is low during INIT.
  always_ff @(posedge Clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.ByteEn[b]) mem[idx][8*b +: 8] <= bus.In[8*b +: 8];
      end
    end
  end

  assign rd_dat   = in_range ? mem[idx] : '0;
  assign wr_err_d = wr_acc && !in_range;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_err_d;
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .vld_i  (rd_acc),
    .err_i  (!in_range),
    .dat_i  (rd_dat),
    .vld_o  (pipe_vld),
    .err_o  (pipe_err),
    .dat_o  (pipe_dat)
  );

  assign bus.OutValid = pipe_vld;
  assign bus.Out      = pipe_dat;
  assign bus.Err      = pipe_err | wr_err_q;
endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Randomised bench for ram_sync_ctrl against a time-stamped response model.
module tb_ram_sync_ctrl;
  import ram_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
`ifdef RAM_INIT_EN
  localparam int INIT_CYC = DEPTH + 1;
  localparam bit CLEARS   = 1'b1;
`else
  localparam int INIT_CYC = 1;
  localparam bit CLEARS   = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;

  ram_sync_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_sync_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // A response is tagged with the clock edge at which a consumer would capture it.
  typedef struct {
    int          due;
    logic [31:0] dat;
    bit          err;
    bit          known;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  int          cyc;
  int          wr_err_due;
  logic [31:0] last_out;
  bit          last_known;
  bit          model_ready;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int low_cycles);
    Rst_n = 1'b0;
    rsp_q.delete();
    wr_err_due  = -1;
    last_out    = '0;
    last_known  = 1'b1;
    model_ready = 1'b0;
    if (CLEARS) begin
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[i] = '0;
        known[i]     = 1'b1;
      end
    end
    repeat (low_cycles) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready",    32'(bus.Ready),    32'd0);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_out",      bus.Out,           32'd0);
    chk("rst_err",      32'(bus.Err),      32'd0);
    Rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < INIT_CYC + 20) begin
      @(posedge Clk);
      n++;
      cyc++;
      @(negedge Clk);
      seen = bus.Ready;
      if (!seen) chk("init_outvalid", 32'(bus.OutValid), 32'd0);
    end
    chk(tag, 32'(n), 32'(INIT_CYC));
    model_ready = seen;
  endtask

  task automatic step(input bit en, input bit rw, input logic [15:0] addr,
                      input logic [31:0] din, input logic [3:0] be);
    rsp_t r;
    bit   exp_vld, exp_err, inr;
    int   a;
    bus.Enable  = en;
    bus.RW      = rw;
    bus.Address = addr;
    bus.In      = din;
    bus.ByteEn  = be;
    @(posedge Clk);
    cyc++;
    a   = int'(addr);
    inr = (a < DEPTH);
    if (en && model_ready) begin
      if (rw == RW_READ) begin
        r.due   = cyc + RD_LAT;
        r.err   = !inr;
        r.dat   = 32'h0;
        r.known = 1'b1;
        if (inr) begin
          r.dat   = model_mem[a];
          r.known = known[a];
        end
        rsp_q.push_back(r);
      end else if (inr) begin
        if (be == 4'hF) known[a] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[a][8*b +: 8] = din[8*b +: 8];
      end else begin
        wr_err_due = cyc + 1;
      end
    end
    @(negedge Clk);
    exp_err = (wr_err_due == cyc + 1);
    exp_vld = (rsp_q.size() > 0) && (rsp_q[0].due == cyc + 1);
    chk("ready",    32'(bus.Ready),    32'(model_ready));
    chk("outvalid", 32'(bus.OutValid), 32'(exp_vld));
    if (exp_vld) begin
      r          = rsp_q.pop_front();
      last_out   = r.dat;
      last_known = r.known;
      exp_err    = exp_err | r.err;
    end
    if (last_known) chk(exp_vld ? "out" : "out_hold", bus.Out, last_out);
    chk("err", 32'(bus.Err), 32'(exp_err));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, RW_READ, 16'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] pat [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    bus.Enable  = 1'b0;
    bus.RW      = RW_READ;
    bus.Address = '0;
    bus.In      = '0;
    bus.ByteEn  = '0;

    do_reset(3);
    // Requests offered during INIT must be dropped.
    bus.Enable = 1'b1; bus.RW = RW_WRITE; bus.Address = 16'h0005;
    bus.In = 32'hDEADBEEF; bus.ByteEn = 4'hF;
    wait_ready("init_len");
    step(1'b1, RW_READ, 16'h0005, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    pat[0] = 32'hAAAAAAAA; pat[1] = 32'hCCCC00AA; pat[2] = 32'hCCCC11BB; pat[3] = 32'hCCCC22CC;
    pat[4] = 32'hCCCC33DD; pat[5] = 32'hCCCC44EE; pat[6] = 32'hCCCC55FF; pat[7] = 32'hCCCCFFFF;
    for (int i = 0; i < 8; i++) step(1'b1, RW_WRITE, 16'(i), pat[i], 4'hF);
    for (int i = 0; i < 8; i++) step(1'b1, RW_READ, 16'(i), 32'h0, 4'h0);
    idle(RD_LAT + 1);

    step(1'b1, RW_WRITE, 16'h0010, 32'hFFFFFFFF, 4'hF);
    step(1'b1, RW_WRITE, 16'h0010, 32'h00000000, 4'b0101);
    step(1'b1, RW_READ,  16'h0010, 32'h0, 4'h0);
    idle(RD_LAT + 1);
    chk("bytemask_word", last_out, 32'hFF00FF00);

    step(1'b1, RW_WRITE, 16'h0020, 32'h12345678, 4'hF);
    step(1'b1, RW_READ,  16'h0020, 32'h0, 4'h0);
    idle(RD_LAT + 1);
    chk("wr_then_rd", last_out, 32'h12345678);

    step(1'b1, RW_WRITE, 16'h0400, 32'hDEADBEEF, 4'hF);
    step(1'b1, RW_READ,  16'h0400, 32'h0, 4'h0);
    step(1'b1, RW_READ,  16'h0000, 32'h0, 4'h0);
    idle(RD_LAT + 1);
    chk("oor_no_alias", last_out, 32'hAAAAAAAA);

    // Reset lands between the first read accept and its response.
    step(1'b1, RW_READ, 16'h0020, 32'h0, 4'h0);
    Rst_n = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("flush_outvalid", 32'(bus.OutValid), 32'd0);
      chk("flush_ready",    32'(bus.Ready),    32'd0);
    end
    do_reset(1);
    bus.Enable = 1'b0;
    wait_ready("init_len2");
    step(1'b1, RW_READ, 16'h0020, 32'h0, 4'h0);
    idle(RD_LAT + 1);

    for (int k = 0; k < 400; k++) begin
      logic [15:0] addr;
      case ($urandom_range(0, 3))
        0:       addr = 16'($urandom_range(0, 31));
        1:       addr = 16'($urandom_range(DEPTH - 4, DEPTH - 1));
        2:       addr = 16'($urandom_range(DEPTH, DEPTH + 6));
        default: addr = 16'($urandom_range(0, 65535));
      endcase
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr,
           32'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(RD_LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
